// File: rtl/shift_sequencer_pkg.sv
// Shared opcode and state definitions for the multi-cycle shift sequencer.
package shift_sequencer_pkg;

  localparam logic [2:0] OP_PASS  = 3'd0;
  localparam logic [2:0] OP_LSR   = 3'd1;
  localparam logic [2:0] OP_LSL   = 3'd2;
  localparam logic [2:0] OP_ROR   = 3'd3;
  localparam logic [2:0] OP_ROL   = 3'd4;
  localparam logic [2:0] OP_ASR   = 3'd5;
  localparam logic [2:0] OP_ROR2  = 3'd6;
  localparam logic [2:0] OP_PASS7 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_pass(input logic [2:0] op);
    return (op == OP_PASS) || (op == OP_PASS7);
  endfunction

endpackage

// File: rtl/shift_sequencer_step_sel.sv
// Picks the shifter code and count decrement for the current iteration.
module shift_sequencer_step_sel
  import shift_sequencer_pkg::*;
#(
  parameter int AMT_W   = 3,
  parameter bit ROR2_EN = 1'b1
) (
  input  logic [2:0]       op_r_i,
  input  logic [AMT_W-1:0] remaining_i,
  output logic [2:0]       code_o,
  output logic [AMT_W-1:0] dec_o
);

  always_comb begin
    code_o = op_r_i;
    dec_o  = AMT_W'(1);
    // Pairs of ROR positions collapse into one rotate-by-2 step.
    if (ROR2_EN && (op_r_i == OP_ROR) && (remaining_i >= AMT_W'(2))) begin
      code_o = OP_ROR2;
      dec_o  = AMT_W'(2);
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterates an external single-step shifter until a 0-7 position request completes.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int AMT_W   = 3,
  parameter bit ROR2_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] obus,
  output logic [WIDTH-1:0] dbus,
  output logic [2:0]       sbus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       step_code;
  logic [AMT_W-1:0] step_dec;

  shift_sequencer_step_sel #(
    .AMT_W   (AMT_W),
    .ROR2_EN (ROR2_EN)
  ) u_step_sel (
    .op_r_i      (op_q),
    .remaining_i (rem_q),
    .code_o      (step_code),
    .dec_o       (step_dec)
  );

  // Shifter-facing outputs depend only on registers, keeping obus out of their cone.
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign dbus = busy ? acc_q : '0;
  assign sbus = busy ? step_code : 3'd0;
  assign dout = dout_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = din;
          op_d  = op;
          rem_d = amount;
          if ((amount == '0) || is_pass(op)) begin
            state_d = ST_DONE;
            dout_d  = din;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = obus;
        rem_d = rem_q - step_dec;
        if (rem_d == '0) begin
          state_d = ST_DONE;
          dout_d  = obus;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      dout_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed table, hand sequences and randomized requests.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [2:0] amount;
  logic [7:0] din;
  logic [7:0] obus;
  logic [7:0] dbus;
  logic [2:0] sbus;
  logic       busy;
  logic       done;
  logic [7:0] dout;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .AMT_W(3), .ROR2_EN(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .amount (amount),
    .din    (din),
    .obus   (obus),
    .dbus   (dbus),
    .sbus   (sbus),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  // External single-step shifter.
  function automatic logic [7:0] shifter(input logic [7:0] d, input logic [2:0] s);
    case (s)
      3'd1:    return d >> 1;
      3'd2:    return d << 1;
      3'd3:    return {d[0], d[7:1]};
      3'd4:    return {d[6:0], d[7]};
      3'd5:    return {d[7], d[7:1]};
      3'd6:    return {d[1:0], d[7:2]};
      default: return d;
    endcase
  endfunction

  assign obus = shifter(dbus, sbus);

  // Whole-request reference: final value by direct arithmetic.
  function automatic logic [7:0] ref_result(input logic [2:0] o, input logic [7:0] d, input logic [2:0] a);
    logic [15:0]       dd;
    logic signed [7:0] sd;
    int                r;
    dd = {d, d};
    sd = d;
    case (o)
      3'd1: return d >> a;
      3'd2: return 8'(d << a);
      3'd3: begin dd = dd >> a; return dd[7:0]; end
      3'd4: begin dd = dd << a; return dd[15:8]; end
      3'd5: return 8'(sd >>> a);
      3'd6: begin r = (2 * int'(a)) % 8; dd = dd >> r; return dd[7:0]; end
      default: return d;
    endcase
  endfunction

  function automatic int ref_steps(input logic [2:0] o, input logic [2:0] a);
    if (o == 3'd0 || o == 3'd7 || a == 3'd0) return 0;
    if (o == 3'd3) return (int'(a) + 1) / 2;
    return int'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic run_req(input logic [2:0] o, input logic [7:0] d, input logic [2:0] a,
                         output logic [7:0] got_dout, output int got_lat,
                         output logic [20:0] got_codes, output int got_steps,
                         output logic done_after);
    logic timed_out;
    @(negedge clk);
    start = 1'b1; op = o; din = d; amount = a;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); din = 8'($urandom); amount = 3'($urandom);
    got_lat = 1; got_steps = 0; got_codes = '0; timed_out = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin timed_out = 1'b0; break; end
      if (busy && got_steps < 7) begin
        got_codes[3*got_steps +: 3] = sbus;
        got_steps++;
      end
      @(negedge clk);
      got_lat++;
    end
    if (timed_out) check("done_timeout", 32'd1, 32'd0);
    got_dout = dout;
    @(negedge clk);
    done_after = done;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  din;
    logic [2:0]  amt;
    logic [7:0]  exp_dout;
    int          exp_lat;
    int          exp_steps;
    logic [20:0] exp_codes;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0]  g_dout;
    int          g_lat, g_steps;
    logic [20:0] g_codes;
    logic        g_after;

    vecs[0] = '{3'd1, 8'hB4, 3'd3, 8'h16, 4, 3, 21'o111};
    vecs[1] = '{3'd3, 8'h81, 3'd5, 8'h0C, 4, 3, 21'o366};
    vecs[2] = '{3'd5, 8'h90, 3'd2, 8'hE4, 3, 2, 21'o55};
    vecs[3] = '{3'd4, 8'hA5, 3'd0, 8'hA5, 1, 0, 21'o0};
    vecs[4] = '{3'd0, 8'h3C, 3'd5, 8'h3C, 1, 0, 21'o0};
    vecs[5] = '{3'd7, 8'hC3, 3'd7, 8'hC3, 1, 0, 21'o0};
    vecs[6] = '{3'd2, 8'h01, 3'd7, 8'h80, 8, 7, 21'o2222222};
    vecs[7] = '{3'd6, 8'h81, 3'd3, 8'h06, 4, 3, 21'o666};
    vecs[8] = '{3'd3, 8'h81, 3'd1, 8'hC0, 2, 1, 21'o3};
    vecs[9] = '{3'd3, 8'h81, 3'd7, 8'h03, 5, 4, 21'o3666};

    reset = 1'b1; start = 1'b0; op = '0; amount = '0; din = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dbus", 32'(dbus), 32'd0);
    check("rst_sbus", 32'(sbus), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].op, vecs[i].din, vecs[i].amt, g_dout, g_lat, g_codes, g_steps, g_after);
      check($sformatf("vec%0d_dout", i), 32'(g_dout), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_steps", i), 32'(g_steps), 32'(vecs[i].exp_steps));
      check($sformatf("vec%0d_sbus_seq", i), 32'(g_codes), 32'(vecs[i].exp_codes));
      check($sformatf("vec%0d_done_1cyc", i), 32'(g_after), 32'd0);
    end

    // ROL 7 with a second start arriving mid-run; it must be dropped.
    @(negedge clk);
    start = 1'b1; op = 3'd4; din = 8'h81; amount = 3'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd1; din = 8'hFF; amount = 3'd1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    g_lat = 3;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      g_lat++;
    end
    check("ign_done", 32'(done), 32'd1);
    check("ign_latency", 32'(g_lat), 32'd8);
    check("ign_dout", 32'(dout), 32'hC0);
    @(negedge clk);
    check("ign_no_rerun", 32'(busy | done), 32'd0);

    // Reset in the second SHIFT cycle of LSR B4 by 3.
    @(negedge clk);
    start = 1'b1; op = 3'd1; din = 8'hB4; amount = 3'd3;
    @(negedge clk);
    start = 1'b0;
    check("mid_busy_pre", 32'(busy), 32'd1);
    check("mid_dbus1", 32'(dbus), 32'hB4);
    @(negedge clk);
    check("mid_dbus2", 32'(dbus), 32'h5A);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_dbus", 32'(dbus), 32'd0);
    check("mid_rst_sbus", 32'(sbus), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_req(3'd1, 8'hB4, 3'd3, g_dout, g_lat, g_codes, g_steps, g_after);
    check("post_rst_dout", 32'(g_dout), 32'h16);
    check("post_rst_latency", 32'(g_lat), 32'd4);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] r_op, r_amt;
      logic [7:0] r_din;
      r_op  = 3'($urandom_range(0, 7));
      r_amt = 3'($urandom_range(0, 7));
      r_din = 8'($urandom);
      run_req(r_op, r_din, r_amt, g_dout, g_lat, g_codes, g_steps, g_after);
      check($sformatf("rnd%0d_op%0d_amt%0d_din%0h_dout", i, r_op, r_amt, r_din),
            32'(g_dout), 32'(ref_result(r_op, r_din, r_amt)));
      check($sformatf("rnd%0d_op%0d_amt%0d_latency", i, r_op, r_amt),
            32'(g_lat), 32'(ref_steps(r_op, r_amt) + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
